// File: rtl/fx_slave_pkg.sv
// fx slave register block: shared offsets, STATUS bit indices, window width.
// Imported by fx_slave_regs and fx_sync_fifo.
package fx_slave_pkg;

    localparam int WIN_W = 5;

    localparam logic [WIN_W-1:0] OFF_ID     = 5'h00;
    localparam logic [WIN_W-1:0] OFF_STATUS = 5'h01;
    localparam logic [WIN_W-1:0] OFF_CTRL   = 5'h02;
    localparam logic [WIN_W-1:0] OFF_FIFO   = 5'h03;
    localparam logic [WIN_W-1:0] OFF_LEVEL  = 5'h04;
    localparam logic [WIN_W-1:0] OFF_WRCNT  = 5'h05;
    localparam logic [WIN_W-1:0] OFF_RDCNT  = 5'h06;
    localparam logic [WIN_W-1:0] OFF_USER   = 5'h10;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_UDF   = 3;

endpackage

// File: rtl/fx_sync_fifo.sv
// Byte FIFO, power-of-2 depth, with push/pop/flush, level and full/empty.
// Ports: clk, rst (sync, high), push/din, pop/dout, flush, empty, full, level, ovf (push dropped).
module fx_sync_fifo
    import fx_slave_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign level = cnt_q;
    assign dout  = empty ? 8'h00 : mem_q[rptr_q];

    // Pop is evaluated first so a full FIFO can take a push in the same cycle.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign ovf     = push & ~flush & full & ~do_pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/fx_slave_regs.sv
// fx-bus responder: 32-byte window of ID/STATUS/CTRL/FIFO/LEVEL/USER regs, FIFO drained by st_* stream.
// Ports: clk_sys, rst, fx write/read strobes, fx_q, ctrl_out, user_regs, st_data/st_vld/st_rdy.
// Option: define FX_STATS_EN for WR_CNT (0x05) / RD_CNT (0x06) counters.
module fx_slave_regs
    import fx_slave_pkg::*;
#(
    parameter logic [21:0] BASE_ADDR  = 22'h010000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  ID_BYTE    = 8'hA5
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic [21:0]  fx_waddr,
    input  logic         fx_wr,
    input  logic [7:0]   fx_data,
    input  logic         fx_rd,
    input  logic [21:0]  fx_raddr,
    output logic [7:0]   fx_q,
    output logic [6:0]   ctrl_out,
    output logic [127:0] user_regs,
    output logic [7:0]   st_data,
    output logic         st_vld,
    input  logic         st_rdy
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [WIN_W-1:0] woff, roff;
    logic             wr_hit, rd_hit;
    logic             wr_status, wr_ctrl, wr_fifo;
    logic             flush;

    logic [7:0] fx_q_q, fx_q_d;
    logic [6:0] ctrl_q, ctrl_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;
    logic [7:0] user_q [16];
    logic [7:0] rdata;

    logic          f_empty, f_full, f_ovf;
    logic [LW-1:0] f_level;
    logic [8:0]    lvl9;
    logic [7:0]    lvl8;
    logic          udf_set;

    assign woff   = fx_waddr[WIN_W-1:0];
    assign roff   = fx_raddr[WIN_W-1:0];
    assign wr_hit = fx_wr & (fx_waddr[21:WIN_W] == BASE_ADDR[21:WIN_W]);
    assign rd_hit = fx_rd & (fx_raddr[21:WIN_W] == BASE_ADDR[21:WIN_W]);

    assign wr_status = wr_hit & (woff == OFF_STATUS);
    assign wr_ctrl   = wr_hit & (woff == OFF_CTRL);
    assign wr_fifo   = wr_hit & (woff == OFF_FIFO);
    assign flush     = wr_ctrl & fx_data[0];

    fx_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (rst),
        .push  (wr_fifo),
        .din   (fx_data),
        .pop   (st_rdy),
        .flush (flush),
        .dout  (st_data),
        .empty (f_empty),
        .full  (f_full),
        .level (f_level),
        .ovf   (f_ovf)
    );

    assign st_vld = ~f_empty;

    // LEVEL only exceeds a byte when FIFO_DEPTH is 256; clamp that case.
    assign lvl9 = 9'(f_level);
    assign lvl8 = lvl9[8] ? 8'hFF : lvl9[7:0];

    // Peeking the FIFO head while empty is an underflow.
    assign udf_set = rd_hit & (roff == OFF_FIFO) & f_empty;

    // Sticky set beats a same-cycle W1C.
    assign ovf_d = f_ovf   | (ovf_q & ~(wr_status & fx_data[ST_OVF]));
    assign udf_d = udf_set | (udf_q & ~(wr_status & fx_data[ST_UDF]));
    assign ctrl_d = wr_ctrl ? fx_data[7:1] : ctrl_q;

`ifdef FX_STATS_EN
    logic [7:0] wr_cnt_q, wr_cnt_d;
    logic [7:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_hit & (woff == OFF_WRCNT)) begin
            wr_cnt_d = 8'h00;
            rd_cnt_d = 8'h00;
        end else begin
            if (wr_hit) wr_cnt_d = wr_cnt_q + 8'd1;
            if (rd_hit) rd_cnt_d = rd_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_cnt_q <= 8'h00;
            rd_cnt_q <= 8'h00;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end
`endif

    always_comb begin
        rdata = 8'h00;
        if (rd_hit) begin
            if (roff[4]) begin
                rdata = user_q[roff[3:0]];
            end else begin
                case (roff)
                    OFF_ID:     rdata = ID_BYTE;
                    OFF_STATUS: rdata = {4'b0, udf_q, ovf_q, f_full, f_empty};
                    OFF_CTRL:   rdata = {ctrl_q, 1'b0};
                    OFF_FIFO:   rdata = st_data;
                    OFF_LEVEL:  rdata = lvl8;
`ifdef FX_STATS_EN
                    OFF_WRCNT:  rdata = wr_cnt_q;
                    OFF_RDCNT:  rdata = rd_cnt_q;
`endif
                    default:    rdata = 8'h00;
                endcase
            end
        end
    end

    assign fx_q_d = fx_rd ? rdata : fx_q_q;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fx_q_q <= 8'h00;
            ctrl_q <= 7'h00;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            for (int i = 0; i < 16; i++) user_q[i] <= 8'h00;
        end else begin
            fx_q_q <= fx_q_d;
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            if (wr_hit & woff[4]) user_q[woff[3:0]] <= fx_data;
        end
    end

    assign fx_q     = fx_q_q;
    assign ctrl_out = ctrl_q;

    for (genvar n = 0; n < 16; n++) begin : g_user
        assign user_regs[8*n +: 8] = user_q[n];
    end

endmodule

// File: tb/tb_fx_slave_regs.sv
// Directed self-checking bench for fx_slave_regs (default depth 16, base 0x010000).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_fx_slave_regs;

    logic         clk_sys = 1'b0;
    logic         rst;
    logic [21:0]  fx_waddr;
    logic         fx_wr;
    logic [7:0]   fx_data;
    logic         fx_rd;
    logic [21:0]  fx_raddr;
    logic [7:0]   fx_q;
    logic [6:0]   ctrl_out;
    logic [127:0] user_regs;
    logic [7:0]   st_data;
    logic         st_vld;
    logic         st_rdy;

    int checks = 0;
    int errors = 0;

    localparam logic [21:0] B = 22'h010000;

    fx_slave_regs dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .fx_waddr  (fx_waddr),
        .fx_wr     (fx_wr),
        .fx_data   (fx_data),
        .fx_rd     (fx_rd),
        .fx_raddr  (fx_raddr),
        .fx_q      (fx_q),
        .ctrl_out  (ctrl_out),
        .user_regs (user_regs),
        .st_data   (st_data),
        .st_vld    (st_vld),
        .st_rdy    (st_rdy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic fx_write(input logic [21:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        fx_wr = 1'b1; fx_waddr = a; fx_data = d;
        @(negedge clk_sys);
        fx_wr = 1'b0;
    endtask

    task automatic fx_read(input logic [21:0] a, output logic [7:0] q);
        @(negedge clk_sys);
        fx_rd = 1'b1; fx_raddr = a;
        @(negedge clk_sys);
        fx_rd = 1'b0;
        q = fx_q;
    endtask

    task automatic apply_reset();
        @(negedge clk_sys);
        rst = 1'b1; fx_wr = 1'b0; fx_rd = 1'b0; st_rdy = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] q;
        apply_reset();
        checks++;
        if (fx_q !== 8'h00 || ctrl_out !== 7'h00 || user_regs !== '0 ||
            st_vld !== 1'b0 || st_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: fx_q=%h ctrl=%h st_vld=%b st_data=%h", fx_q, ctrl_out, st_vld, st_data);
        end
        fx_read(B + 22'h00, q);
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL id: got %h want a5", q); end
        fx_read(B + 22'h01, q);
        checks++;
        if (q !== 8'h01) begin errors++; $display("FAIL status_empty: got %h want 01", q); end
    endtask

    task automatic test_user();
        logic [7:0] q;
        fx_write(B + 22'h13, 8'h5A);
        checks++;
        if (user_regs[31:24] !== 8'h5A) begin
            errors++; $display("FAIL user_out: got %h want 5a", user_regs[31:24]);
        end
        fx_read(B + 22'h13, q);
        checks++;
        if (q !== 8'h5A) begin errors++; $display("FAIL user_rd: got %h want 5a", q); end
        fx_read(22'h020013, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL miss_rd: got %h want 00", q); end
        fx_write(22'h020013, 8'hFF);
        fx_read(B + 22'h13, q);
        checks++;
        if (q !== 8'h5A) begin errors++; $display("FAIL miss_wr: got %h want 5a", q); end
        fx_read(B + 22'h08, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reserved: got %h want 00", q); end
    endtask

    task automatic test_sticky();
        logic [7:0] q;
        fx_read(B + 22'h03, q);
        fx_read(B + 22'h01, q);
        checks++;
        if (q !== 8'h09) begin errors++; $display("FAIL udf_set: got %h want 09", q); end
        // Underflow re-set and W1C on the same cycle: set must win.
        @(negedge clk_sys);
        fx_rd = 1'b1; fx_raddr = B + 22'h03;
        fx_wr = 1'b1; fx_waddr = B + 22'h01; fx_data = 8'h08;
        @(negedge clk_sys);
        fx_rd = 1'b0; fx_wr = 1'b0;
        fx_read(B + 22'h01, q);
        checks++;
        if (q !== 8'h09) begin errors++; $display("FAIL set_wins: got %h want 09", q); end
        fx_write(B + 22'h01, 8'h08);
        fx_read(B + 22'h01, q);
        checks++;
        if (q !== 8'h01) begin errors++; $display("FAIL udf_clr: got %h want 01", q); end
    endtask

    task automatic test_fifo_fill();
        logic [7:0] q;
        st_rdy = 1'b0;
        for (int i = 0; i < 17; i++) fx_write(B + 22'h03, 8'(i));
        fx_read(B + 22'h04, q);
        checks++;
        if (q !== 8'h10) begin errors++; $display("FAIL level_full: got %h want 10", q); end
        fx_read(B + 22'h01, q);
        checks++;
        if (q !== 8'h06) begin errors++; $display("FAIL status_ovf: got %h want 06", q); end
        fx_read(B + 22'h03, q);
        checks++;
        if (q !== 8'h00 || st_vld !== 1'b1) begin
            errors++; $display("FAIL peek: got %h vld %b want 00 1", q, st_vld);
        end
        @(negedge clk_sys);
        st_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (st_vld !== 1'b1 || st_data !== 8'(i)) begin
                errors++; $display("FAIL drain[%0d]: got %h vld %b want %h", i, st_data, st_vld, 8'(i));
            end
            @(negedge clk_sys);
        end
        checks++;
        if (st_vld !== 1'b0) begin errors++; $display("FAIL drained: st_vld %b want 0", st_vld); end
        st_rdy = 1'b0;
        fx_write(B + 22'h01, 8'h04);
        fx_read(B + 22'h01, q);
        checks++;
        if (q !== 8'h01) begin errors++; $display("FAIL ovf_clr: got %h want 01", q); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] q;
        logic [7:0] exp;
        st_rdy = 1'b0;
        for (int i = 0; i < 16; i++) fx_write(B + 22'h03, 8'h20 + 8'(i));
        @(negedge clk_sys);
        st_rdy = 1'b1; fx_wr = 1'b1; fx_waddr = B + 22'h03; fx_data = 8'h77;
        @(negedge clk_sys);
        st_rdy = 1'b0; fx_wr = 1'b0;
        fx_read(B + 22'h04, q);
        checks++;
        if (q !== 8'h10) begin errors++; $display("FAIL pp_level: got %h want 10", q); end
        fx_read(B + 22'h01, q);
        checks++;
        if (q !== 8'h02) begin errors++; $display("FAIL pp_status: got %h want 02", q); end
        @(negedge clk_sys);
        st_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 8'h77 : 8'h21 + 8'(i);
            checks++;
            if (st_vld !== 1'b1 || st_data !== exp) begin
                errors++; $display("FAIL pp_drain[%0d]: got %h want %h", i, st_data, exp);
            end
            @(negedge clk_sys);
        end
        st_rdy = 1'b0;
    endtask

    task automatic test_flush();
        logic [7:0] q;
        st_rdy = 1'b0;
        for (int i = 0; i < 5; i++) fx_write(B + 22'h03, 8'h40 + 8'(i));
        fx_write(B + 22'h02, 8'h03);
        checks++;
        if (ctrl_out !== 7'h01 || st_vld !== 1'b0) begin
            errors++; $display("FAIL flush: ctrl %h vld %b want 01 0", ctrl_out, st_vld);
        end
        fx_read(B + 22'h04, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL flush_level: got %h want 00", q); end
        fx_read(B + 22'h02, q);
        checks++;
        if (q !== 8'h02) begin errors++; $display("FAIL ctrl_rd: got %h want 02", q); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q;
        apply_reset();
        fx_read(B + 22'h00, q);
        @(negedge clk_sys);
        fx_wr = 1'b1; fx_waddr = B + 22'h10; fx_data = 8'h11;
        fx_rd = 1'b1; fx_raddr = B + 22'h10;
        @(negedge clk_sys);
        fx_wr = 1'b0; fx_rd = 1'b0;
        checks++;
        if (fx_q !== 8'h00) begin errors++; $display("FAIL rw_old: got %h want 00", fx_q); end
        fx_read(B + 22'h10, q);
        checks++;
        if (q !== 8'h11) begin errors++; $display("FAIL rw_new: got %h want 11", q); end
`ifdef FX_STATS_EN
        fx_read(B + 22'h06, q);
        checks++;
        if (q !== 8'h03) begin errors++; $display("FAIL rd_cnt: got %h want 03", q); end
        fx_read(B + 22'h05, q);
        checks++;
        if (q !== 8'h01) begin errors++; $display("FAIL wr_cnt: got %h want 01", q); end
`else
        fx_write(B + 22'h05, 8'hFF);
        fx_read(B + 22'h05, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL no_stats: got %h want 00", q); end
`endif
    endtask

    initial begin
        rst = 1'b1; fx_wr = 1'b0; fx_rd = 1'b0; st_rdy = 1'b0;
        fx_waddr = '0; fx_raddr = '0; fx_data = '0;
        test_reset();
        test_user();
        test_sticky();
        test_fifo_fill();
        test_full_push_pop();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
